// File: rtl/led_sweep_checker_if.sv
// Bundle between the LED-bus sampler side and the sweep checker: sample qualifier, bus word, counter clear,
// and the checker's lock/step/pulse/counter status outputs.
interface led_sweep_checker_if #(
  parameter int W_ERR = 8,
  parameter int W_FRM = 16
);
  logic             vld;
  logic [7:0]       led;
  logic             clr;
  logic             locked;
  logic [2:0]       step;
  logic             err;
  logic             frame;
  logic [W_ERR-1:0] err_cnt;
  logic [W_FRM-1:0] frm_cnt;

  modport master (
    output vld, led, clr,
    input  locked, step, err, frame, err_cnt, frm_cnt
  );

  modport slave (
    input  vld, led, clr,
    output locked, step, err, frame, err_cnt, frm_cnt
  );
endinterface

// File: rtl/led_sweep_checker.sv
// Mirror-sweep LED bus monitor: locks on 8'h00, tracks the 8-step sweep, pulses err/frame and counts them.
// Latency 1 clk from a vld sample to every output; no backpressure, words are taken only when vld=1.
module led_sweep_checker #(
  parameter int W_ERR = 8,
  parameter int W_FRM = 16
) (
  input logic              clk,
  input logic              rst_n,
  led_sweep_checker_if.slave mon
);

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  localparam logic [7:0] SYNC_WORD = 8'h00;

  function automatic logic [7:0] sweep_word(input logic [2:0] idx);
    logic [7:0] w;
    w = 8'h00;
    case (idx)
      3'd0: w = 8'h81;
      3'd1: w = 8'h42;
      3'd2: w = 8'h24;
      3'd3: w = 8'h18;
      3'd4: w = 8'h24;
      3'd5: w = 8'h42;
      3'd6: w = 8'h81;
      3'd7: w = 8'h00;
      default: w = 8'h00;
    endcase
    return w;
  endfunction

  state_t           state_q, state_d;
  logic [2:0]       step_q, step_d;
  logic             err_q, err_d;
  logic             frame_q, frame_d;
  logic [W_ERR-1:0] err_cnt_q, err_cnt_d;
  logic [W_FRM-1:0] frm_cnt_q, frm_cnt_d;

  logic [2:0]       step_nxt;
  logic [7:0]       exp_word;
  logic             word_match;
  logic             is_sync;

  assign step_nxt   = step_q + 3'd1;
  assign exp_word   = sweep_word(step_nxt);
  assign word_match = (mon.led == exp_word);
  assign is_sync    = (mon.led == SYNC_WORD);

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    err_d   = 1'b0;
    frame_d = 1'b0;

    if (mon.vld) begin
      case (state_q)
        HUNT: begin
          // Lock on the sync word, but the sweep leading up to it was not seen, so no frame.
          if (is_sync) begin
            state_d = LOCK;
            step_d  = 3'd7;
          end
        end
        LOCK: begin
          if (word_match) begin
            step_d  = step_nxt;
            frame_d = (step_nxt == 3'd7);
          end else begin
            err_d = 1'b1;
            // A stray 00 (e.g. generator disabled mid-sweep) is itself a sync point.
            if (is_sync) begin
              step_d = 3'd7;
            end else begin
              state_d = HUNT;
            end
          end
        end
        default: begin
          state_d = HUNT;
        end
      endcase
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    frm_cnt_d = frm_cnt_q;
    if (mon.clr) begin
      err_cnt_d = '0;
      frm_cnt_d = '0;
    end else begin
      if (err_d && !(&err_cnt_q)) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
      if (frame_d && !(&frm_cnt_q)) begin
        frm_cnt_d = frm_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HUNT;
      step_q    <= 3'd7;
      err_q     <= 1'b0;
      frame_q   <= 1'b0;
      err_cnt_q <= '0;
      frm_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      err_q     <= err_d;
      frame_q   <= frame_d;
      err_cnt_q <= err_cnt_d;
      frm_cnt_q <= frm_cnt_d;
    end
  end

  assign mon.locked  = (state_q == LOCK);
  assign mon.step    = step_q;
  assign mon.err     = err_q;
  assign mon.frame   = frame_q;
  assign mon.err_cnt = err_cnt_q;
  assign mon.frm_cnt = frm_cnt_q;

endmodule

// File: tb/tb_led_sweep_checker.sv
// Randomized and directed checks of led_sweep_checker against a sequence-level reference model.
module tb_led_sweep_checker;

  localparam int W_ERR   = 8;
  localparam int W_FRM   = 16;
  localparam int ERR_MAX = (1 << W_ERR) - 1;
  localparam int FRM_MAX = (1 << W_FRM) - 1;

  logic clk;
  logic rst_n;

  led_sweep_checker_if #(.W_ERR(W_ERR), .W_FRM(W_FRM)) bus ();

  led_sweep_checker #(.W_ERR(W_ERR), .W_FRM(W_FRM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mon   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  byte unsigned sweep_tbl [8] = '{8'h81, 8'h42, 8'h24, 8'h18, 8'h24, 8'h42, 8'h81, 8'h00};

  // Reference model: sequence position as a plain integer index into the table.
  bit m_locked;
  int m_step;
  bit m_err;
  bit m_frame;
  int m_errc;
  int m_frmc;

  function automatic void model_reset();
    m_locked = 0; m_step = 7; m_err = 0; m_frame = 0; m_errc = 0; m_frmc = 0;
  endfunction

  function automatic void model_sample(input bit v, input byte unsigned l, input bit c);
    m_err = 0;
    m_frame = 0;
    if (v) begin
      if (!m_locked) begin
        if (l == 8'h00) begin
          m_locked = 1;
          m_step = 7;
        end
      end else if (l == sweep_tbl[(m_step + 1) % 8]) begin
        m_step = (m_step + 1) % 8;
        m_frame = (m_step == 7);
      end else begin
        m_err = 1;
        if (l == 8'h00) m_step = 7;
        else m_locked = 0;
      end
    end
    if (c) begin
      m_errc = 0;
      m_frmc = 0;
    end else begin
      if (m_err) m_errc = (m_errc >= ERR_MAX) ? ERR_MAX : m_errc + 1;
      if (m_frame) m_frmc = (m_frmc >= FRM_MAX) ? FRM_MAX : m_frmc + 1;
    end
  endfunction

  function automatic logic [29:0] obs();
    return {bus.locked, bus.step, bus.err, bus.frame, bus.err_cnt, bus.frm_cnt};
  endfunction

  function automatic logic [29:0] expv();
    logic [2:0] s;
    logic [7:0] ec;
    logic [15:0] fc;
    s = m_step[2:0];
    ec = m_errc[7:0];
    fc = m_frmc[15:0];
    return {m_locked, s, m_err, m_frame, ec, fc};
  endfunction

  task automatic apply(input bit v, input byte unsigned l, input bit c);
    @(negedge clk);
    bus.vld = v;
    bus.led = l;
    bus.clr = c;
    model_sample(v, l, c);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.vld = 1'b0; bus.led = 8'h00; bus.clr = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n_vec++;
    if (obs() !== {1'b0, 3'd7, 1'b0, 1'b0, 8'd0, 16'd0}) begin
      n_err++;
      $display("FAIL reset_state: got %h want %h", obs(), {1'b0, 3'd7, 1'b0, 1'b0, 8'd0, 16'd0});
    end
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 8; i++) begin
      apply(1, sweep_tbl[i], 0);
      n_vec++;
      if (obs() !== expv()) begin
        n_err++;
        $display("FAIL sweep1[%0d]: got %h want %h", i, obs(), expv());
      end
    end
    n_vec++;
    if (bus.locked !== 1'b1 || bus.frame !== 1'b0) begin
      n_err++;
      $display("FAIL sweep_first_lock: got locked=%0b frame=%0b want locked=1 frame=0", bus.locked, bus.frame);
    end
    for (int i = 0; i < 8; i++) begin
      apply(1, sweep_tbl[i], 0);
      n_vec++;
      if (obs() !== expv() || bus.step !== 3'(i)) begin
        n_err++;
        $display("FAIL sweep2[%0d]: got %h want %h (step want %0d)", i, obs(), expv(), i);
      end
    end
    n_vec++;
    if (bus.frame !== 1'b1 || bus.frm_cnt !== 16'd1 || bus.err_cnt !== 8'd0) begin
      n_err++;
      $display("FAIL sweep_frame: got frame=%0b frm_cnt=%0d err_cnt=%0d want 1/1/0",
               bus.frame, bus.frm_cnt, bus.err_cnt);
    end
  endtask

  task automatic test_skip();
    byte unsigned seq [4] = '{8'h81, 8'h42, 8'h18, 8'h00};
    for (int i = 0; i < 4; i++) begin
      apply(1, seq[i], 0);
      n_vec++;
      if (obs() !== expv()) begin
        n_err++;
        $display("FAIL skip[%0d]: got %h want %h", i, obs(), expv());
      end
      if (i == 2) begin
        n_vec++;
        if (bus.err !== 1'b1 || bus.locked !== 1'b0 || bus.err_cnt !== 8'd1) begin
          n_err++;
          $display("FAIL skip_err: got err=%0b locked=%0b err_cnt=%0d want 1/0/1", bus.err, bus.locked, bus.err_cnt);
        end
      end
    end
    n_vec++;
    if (bus.locked !== 1'b1 || bus.step !== 3'd7 || bus.err !== 1'b0) begin
      n_err++;
      $display("FAIL skip_relock: got locked=%0b step=%0d err=%0b want 1/7/0", bus.locked, bus.step, bus.err);
    end
  endtask

  task automatic test_resync();
    for (int i = 0; i < 4; i++) apply(1, sweep_tbl[i], 0);
    n_vec++;
    if (bus.step !== 3'd3 || obs() !== expv()) begin
      n_err++;
      $display("FAIL resync_at3: got %h want %h", obs(), expv());
    end
    apply(1, 8'h00, 0);
    n_vec++;
    if (bus.err !== 1'b1 || bus.locked !== 1'b1 || bus.step !== 3'd7 || bus.err_cnt !== 8'd2) begin
      n_err++;
      $display("FAIL resync_00: got err=%0b locked=%0b step=%0d err_cnt=%0d want 1/1/7/2",
               bus.err, bus.locked, bus.step, bus.err_cnt);
    end
    apply(1, 8'h81, 0);
    n_vec++;
    if (bus.step !== 3'd0 || bus.err !== 1'b0 || obs() !== expv()) begin
      n_err++;
      $display("FAIL resync_81: got %h want %h", obs(), expv());
    end
  endtask

  task automatic test_vld_toggle();
    int frames;
    int errs;
    int pos;
    frames = 0;
    errs = 0;
    apply(1, 8'h00, 0);
    pos = 0;
    for (int i = 0; i < 64; i++) begin
      if (i % 2 == 0) begin
        apply(1, sweep_tbl[pos], 0);
        pos = (pos + 1) % 8;
      end else begin
        apply(0, byte'($urandom), 0);
      end
      frames += bus.frame;
      errs += bus.err;
      n_vec++;
      if (obs() !== expv()) begin
        n_err++;
        $display("FAIL toggle[%0d]: got %h want %h", i, obs(), expv());
      end
    end
    n_vec++;
    if (frames != 4 || errs != 0) begin
      n_err++;
      $display("FAIL toggle_counts: got frames=%0d errs=%0d want 4/0", frames, errs);
    end
  endtask

  task automatic test_saturation();
    apply(1, 8'h00, 0);
    for (int i = 0; i < 300; i++) apply(1, 8'h00, 0);
    n_vec++;
    if (bus.err_cnt !== 8'd255 || obs() !== expv()) begin
      n_err++;
      $display("FAIL sat_hold: got err_cnt=%0d want 255 (full %h vs %h)", bus.err_cnt, obs(), expv());
    end
    apply(1, 8'h00, 1);
    n_vec++;
    if (bus.err_cnt !== 8'd0 || bus.err !== 1'b1 || bus.frm_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL sat_clr: got err_cnt=%0d err=%0b frm_cnt=%0d want 0/1/0", bus.err_cnt, bus.err, bus.frm_cnt);
    end
  endtask

  task automatic test_random();
    bit v;
    bit c;
    byte unsigned l;
    int r;
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 63) == 0);
      r = $urandom_range(0, 9);
      if (r < 6 && m_locked) l = sweep_tbl[(m_step + 1) % 8];
      else if (r < 8) l = sweep_tbl[$urandom_range(0, 7)];
      else l = byte'($urandom);
      apply(v, l, c);
      n_vec++;
      if (obs() !== expv()) begin
        n_err++;
        $display("FAIL random[%0d]: got %h want %h", i, obs(), expv());
      end
      n_vec++;
      if (bus.err === 1'b1 && bus.frame === 1'b1) begin
        n_err++;
        $display("FAIL random_excl[%0d]: got err=1 frame=1 want not both", i);
      end
    end
  endtask

  task automatic test_reset_mid();
    apply(1, 8'h00, 0);
    for (int i = 0; i < 6; i++) apply(1, sweep_tbl[i], 0);
    n_vec++;
    if (bus.step !== 3'd5 || bus.locked !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_pre: got step=%0d locked=%0b want 5/1", bus.step, bus.locked);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if (obs() !== {1'b0, 3'd7, 1'b0, 1'b0, 8'd0, 16'd0}) begin
      n_err++;
      $display("FAIL rstmid_async: got %h want %h", obs(), {1'b0, 3'd7, 1'b0, 1'b0, 8'd0, 16'd0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    apply(1, 8'h24, 0);
    apply(1, 8'h42, 0);
    n_vec++;
    if (bus.locked !== 1'b0 || bus.err !== 1'b0 || bus.err_cnt !== 8'd0 || obs() !== expv()) begin
      n_err++;
      $display("FAIL rstmid_hunt: got %h want %h", obs(), expv());
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_skip();
    test_resync();
    test_vld_toggle();
    test_saturation();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
